// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC front end.
//   fetch_state_e : instruction-fetch FSM encoding (idle / request / hold)
//   IrNop         : value the instruction register resets to
//   DefaultAw/Iw  : default word-address and instruction widths
package sisc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StHold = 2'b10
    } fetch_state_e;

    localparam logic [31:0] IrNop     = 32'h0000_0000;
    localparam int unsigned DefaultAw = 16;
    localparam int unsigned DefaultIw = 32;

endpackage

// File: rtl/ifetch_unit_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst_f : clock and synchronous active-low reset (loads RESET_PC)
//   load       : branch redirect, takes priority over inc
//   target     : redirect address
//   inc        : advance to the next word (wraps modulo 2^AW)
//   pc         : current program counter
//   pc_nxt     : value pc takes at the next edge (used to launch requests)
module pc_reg
    import sisc_pkg::*;
#(
    parameter int unsigned     AW       = DefaultAw,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          load,
    input  logic [AW-1:0] target,
    input  logic          inc,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        if (load) begin
            pc_nxt = target;
        end else if (inc) begin
            pc_nxt = pc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage feeding the SISC core's instruction register.
// Fetches one word at a time over a req/ack handshake (no prefetch), holds
// the word in ir until the consumer takes it, and honours branch redirects.
// A request that is overtaken by a branch stays on the bus at its original
// address until acked; its data is then dropped (squash).
// Ports:
//   clk, rst_f            : clock, synchronous active-low reset
//   imem_req/imem_addr    : read request and word address (held until ack)
//   imem_ack/imem_rdata   : one-cycle ack with data
//   ir/ir_valid/ir_pc     : instruction register, live flag, fetch address
//   ir_ready              : consumer accepts ir this cycle
//   br_taken/br_target    : redirect pulse and target address
//   fetch_cnt/stall_cnt   : saturating performance counters, present only
//                           when IFETCH_PERF_EN is defined
module ifetch_unit
    import sisc_pkg::*;
#(
    parameter int unsigned   AW       = DefaultAw,
    parameter int unsigned   IW       = DefaultIw,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] ir,
    output logic          ir_valid,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    fetch_state_e  state;
    logic          squash;
    logic          accept;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_nxt;

    // A returned word is kept only if no branch has overtaken it.
    assign accept = (state == StReq) && imem_ack && !squash && !br_taken;

    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_f  (rst_f),
        .load   (br_taken),
        .target (br_target),
        .inc    (accept),
        .pc     (pc),
        .pc_nxt (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state     <= StIdle;
            squash    <= 1'b0;
            ir        <= IW'(IrNop);
            ir_valid  <= 1'b0;
            ir_pc     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            if (br_taken) begin
                ir_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    state     <= StReq;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_nxt;
                end
                StReq: begin
                    if (imem_ack) begin
                        if (squash || br_taken) begin
                            // Drop the word and re-request from the redirected pc.
                            squash    <= 1'b0;
                            imem_addr <= pc_nxt;
                        end else begin
                            ir        <= imem_rdata;
                            ir_pc     <= pc;
                            ir_valid  <= 1'b1;
                            imem_req  <= 1'b0;
                            state     <= StHold;
                        end
                    end else if (br_taken) begin
                        // Request must stay stable on the bus; remember to drop it.
                        squash <= 1'b1;
                    end
                end
                StHold: begin
                    if (br_taken || ir_ready) begin
                        state     <= StReq;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_nxt;
                        ir_valid  <= 1'b0;
                    end
                end
                default: begin
                    state    <= StIdle;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept && (fetch_cnt != 16'hFFFF)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if ((state == StReq) && !imem_ack && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a memory responder acks requests after
// a programmable delay, expected (pc, word) pairs are queued per scenario and
// popped when ir_valid appears. A background checker verifies imem_addr stays
// put while a request is outstanding. Define IFETCH_PERF_EN to also check the
// performance counters.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    ifetch_unit dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_pc      (ir_pc),
        .ir_ready   (ir_ready),
        .br_taken   (br_taken),
        .br_target  (br_target)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [logic [15:0]];
    bit          resp_en = 1'b0;
    int          ack_delay = 1;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hBAD0, a};
    endfunction

    task automatic push_exp(input logic [15:0] a);
        exp_t e;
        e.pc   = a;
        e.data = mem_rd(a);
        exp_q.push_back(e);
    endtask

    // Memory responder: ack on the (ack_delay+1)-th cycle a request is seen.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_en) begin
                imem_ack = 1'b0;
                if (imem_req) begin
                    if (cnt >= ack_delay) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_rd(imem_addr);
                        cnt        = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Address must not move while a request is pending without ack.
    initial begin
        bit          pend;
        bit          preq;
        logic [15:0] paddr;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && imem_req) begin
                nvec++;
                if (imem_addr !== paddr) begin
                    nerr++;
                    $display("FAIL addr_stable: imem_addr=%h, required %h", imem_addr, paddr);
                end
            end
            paddr = imem_addr;
            preq  = imem_req;
            @(posedge clk);
            pend = preq && !imem_ack && rst_f;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic do_reset();
        rst_f    = 1'b0;
        br_taken = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic wait_ir(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resp_en = 1'b1;
        rst_f   = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 16'h0) begin
            nerr++;
            $display("FAIL reset_state: req=%b valid=%b ir=%h ir_pc=%h, required 0 0 0 0",
                     imem_req, ir_valid, ir, ir_pc);
        end
`ifdef IFETCH_PERF_EN
        nvec++;
        if (fetch_cnt !== 16'h0 || stall_cnt !== 16'h0) begin
            nerr++;
            $display("FAIL reset_cnt: fetch=%h stall=%h, required 0 0", fetch_cnt, stall_cnt);
        end
`endif
        rst_f = 1'b1;
        @(negedge clk);
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            nerr++;
            $display("FAIL first_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequence();
        bit   ok;
        exp_t e;
        mem[16'h0] = 32'h11; mem[16'h1] = 32'h22; mem[16'h2] = 32'h33;
        ack_delay = 1;
        ir_ready  = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) push_exp(16'(k));
        for (int k = 0; k < 3; k++) begin
            wait_ir(40, ok);
            e = exp_q.pop_front();
            nvec++;
            if (!ok || ir !== e.data || ir_pc !== e.pc) begin
                nerr++;
                $display("FAIL seq_ir[%0d]: ok=%0d ir=%h ir_pc=%h, required ir=%h ir_pc=%h",
                         k, ok, ir, ir_pc, e.data, e.pc);
            end
            @(negedge clk);
            nvec++;
            if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== e.pc + 16'd1) begin
                nerr++;
                $display("FAIL seq_next[%0d]: valid=%b req=%b addr=%h, required 0 1 %h",
                         k, ir_valid, imem_req, imem_addr, e.pc + 16'd1);
            end
        end
    endtask

    task automatic test_stall();
        bit   ok;
        int   req_cycles;
        exp_t e;
        mem[16'h0] = 32'hAAAA_0001;
        ack_delay  = 3;
        ir_ready   = 1'b1;
        do_reset();
        push_exp(16'h0);
        ok = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ir_valid) begin
                ok = 1'b1;
                break;
            end
            if (imem_req) req_cycles++;
        end
        e = exp_q.pop_front();
        nvec++;
        if (!ok || req_cycles != 4 || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL stall: ok=%0d req_cycles=%0d ir=%h ir_pc=%h, required 1 4 %h %h",
                     ok, req_cycles, ir, ir_pc, e.data, e.pc);
        end
`ifdef IFETCH_PERF_EN
        nvec++;
        if (stall_cnt !== 16'd3 || fetch_cnt !== 16'd1) begin
            nerr++;
            $display("FAIL stall_cnt: stall=%0d fetch=%0d, required 3 1", stall_cnt, fetch_cnt);
        end
`endif
        ack_delay = 1;
    endtask

    task automatic test_hold();
        bit   ok;
        exp_t e;
        mem[16'h0] = 32'h0000_005A; mem[16'h1] = 32'h0000_006B;
        ack_delay  = 1;
        ir_ready   = 1'b0;
        do_reset();
        push_exp(16'h0);
        push_exp(16'h1);
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL hold_first: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (ir !== e.data || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
                nerr++;
                $display("FAIL hold_stable[%0d]: ir=%h valid=%b req=%b, required %h 1 0",
                         i, ir, ir_valid, imem_req, e.data);
            end
        end
        ir_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h1) begin
            nerr++;
            $display("FAIL hold_release: valid=%b req=%b addr=%h, required 0 1 0001",
                     ir_valid, imem_req, imem_addr);
        end
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL hold_second: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
    endtask

    task automatic test_branch_squash();
        bit   ok;
        bit   hit;
        exp_t e;
        mem[16'h0005] = 32'h5555_5555; mem[16'h0040] = 32'h4040_4040;
        ack_delay = 2;
        ir_ready  = 1'b1;
        do_reset();
        push_exp(16'h0040);
        @(negedge clk);
        br_taken = 1'b1; br_target = 16'h0005;
        @(negedge clk);
        br_taken = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 16'h0005) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        nvec++;
        if (!hit) begin
            nerr++;
            $display("FAIL squash_req5: request at 0005 seen=%0d, required 1", hit);
        end
        br_taken = 1'b1; br_target = 16'h0040;
        @(negedge clk);
        br_taken = 1'b0;
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL squash_ir: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
        ack_delay = 1;
    endtask

    task automatic test_branch_ack();
        bit   ok;
        exp_t e;
        mem[16'h0080] = 32'h8080_0080;
        ack_delay = 1;
        ir_ready  = 1'b1;
        do_reset();
        push_exp(16'h0080);
        @(negedge clk);
        @(negedge clk);
        br_taken = 1'b1; br_target = 16'h0080;  // coincides with the ack for 0000
        @(negedge clk);
        br_taken = 1'b0;
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0080 || ir_valid !== 1'b0 || ir !== 32'h0) begin
            nerr++;
            $display("FAIL brack_redirect: req=%b addr=%h valid=%b ir=%h, required 1 0080 0 0",
                     imem_req, imem_addr, ir_valid, ir);
        end
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL brack_ir: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
    endtask

    task automatic test_branch_hold();
        bit   ok;
        exp_t e;
        mem[16'h0] = 32'h0000_00C0; mem[16'h0020] = 32'h2020_0020;
        ack_delay = 1;
        ir_ready  = 1'b0;
        do_reset();
        push_exp(16'h0);
        push_exp(16'h0020);
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL brhold_first: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
        br_taken = 1'b1; br_target = 16'h0020; ir_ready = 1'b1;
        @(negedge clk);
        br_taken = 1'b0;
        nvec++;
        if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
            nerr++;
            $display("FAIL brhold_redirect: valid=%b req=%b addr=%h, required 0 1 0020",
                     ir_valid, imem_req, imem_addr);
        end
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL brhold_ir: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
    endtask

    task automatic test_wrap();
        bit   ok;
        exp_t e;
        mem[16'hFFFF] = 32'hFFFF_0001; mem[16'h0] = 32'h0000_0002;
        ack_delay = 1;
        ir_ready  = 1'b1;
        do_reset();
        push_exp(16'hFFFF);
        push_exp(16'h0000);
        @(negedge clk);
        br_taken = 1'b1; br_target = 16'hFFFF;
        @(negedge clk);
        br_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_ir(40, ok);
            e = exp_q.pop_front();
            nvec++;
            if (!ok || ir !== e.data || ir_pc !== e.pc) begin
                nerr++;
                $display("FAIL wrap_ir[%0d]: ok=%0d ir=%h ir_pc=%h, required %h %h",
                         k, ok, ir, ir_pc, e.data, e.pc);
            end
            if (k == 0) begin
                @(negedge clk);
                nvec++;
                if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
                    nerr++;
                    $display("FAIL wrap_addr: req=%b addr=%h, required 1 0000",
                             imem_req, imem_addr);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        mem[16'h0] = 32'h0000_0011;
        ack_delay = 1;
        ir_ready  = 1'b1;
        do_reset();
        wait_ir(40, ok);
        @(negedge clk);
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
            nerr++;
            $display("FAIL rmid_pending: req=%b addr=%h, required 1 0001", imem_req, imem_addr);
        end
        resp_en  = 1'b0;
        imem_ack = 1'b0;
        rst_f    = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        nvec++;
        if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 32'h0 || ir_pc !== 16'h0) begin
            nerr++;
            $display("FAIL rmid_state: req=%b valid=%b ir=%h ir_pc=%h, required 0 0 0 0",
                     imem_req, ir_valid, ir, ir_pc);
        end
        rst_f   = 1'b1;
        resp_en = 1'b1;
        exp_q.delete();
        push_exp(16'h0);
        @(negedge clk);
        nvec++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            nerr++;
            $display("FAIL rmid_restart: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        wait_ir(40, ok);
        e = exp_q.pop_front();
        nvec++;
        if (!ok || ir !== e.data || ir_pc !== e.pc) begin
            nerr++;
            $display("FAIL rmid_ir: ok=%0d ir=%h ir_pc=%h, required %h %h",
                     ok, ir, ir_pc, e.data, e.pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_hold();
        test_branch_squash();
        test_branch_ack();
        test_branch_hold();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
